// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the sequential Booth multiplier
package mult_pkg;
    localparam int WIDTH  = 32;
    localparam int ITERS  = 32;
    localparam int PROD_W = 2 * WIDTH + 1;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/cla_adder32.sv
// rtl/cla_adder32.sv - 32-bit carry-lookahead adder from four 8-bit generate/propagate groups
module cla_adder32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_carry;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_gg = '0;
        w_gp = '1;
        for (int grp = 0; grp < 4; grp++) begin
            for (int k = 0; k < 8; k++) begin
                w_gg[grp] = w_g[grp*8+k] | (w_p[grp*8+k] & w_gg[grp]);
                w_gp[grp] = w_gp[grp] & w_p[grp*8+k];
            end
        end
    end

    // Group carries are fully expanded so no carry ripples between groups.
    assign w_gc[0] = i_cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    always_comb begin
        logic c;
        w_carry = '0;
        c       = 1'b0;
        for (int grp = 0; grp < 4; grp++) begin
            c = w_gc[grp];
            for (int k = 0; k < 8; k++) begin
                w_carry[grp*8+k] = c;
                c = w_g[grp*8+k] | (w_p[grp*8+k] & c);
            end
        end
    end

    assign o_sum  = w_p ^ w_carry;
    assign o_cout = w_gc[4];
endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - radix-2 Booth signed multiplier, one iteration per clock, 32 iterations
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_mcand;
    logic [PROD_W-1:0]   r_prod;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_result;
    logic                r_exception;

    logic                w_start;
    logic                w_last;
    logic [WIDTH-1:0]    w_addend;
    logic                w_cin;
    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic                w_sum_sign;
    logic [PROD_W-1:0]   w_prod_next;
    logic                w_exc_next;

    assign w_start = ctrl_MULT && (r_state != RUN);
    assign w_last  = (r_cnt == LAST_ITER);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = w_start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Booth pair 01 adds, 10 subtracts via inverted operand plus carry-in, 00/11 add zero.
    always_comb begin
        w_addend = '0;
        w_cin    = 1'b0;
        case (r_prod[1:0])
            2'b01: w_addend = r_mcand;
            2'b10: begin
                w_addend = ~r_mcand;
                w_cin    = 1'b1;
            end
            default: w_addend = '0;
        endcase
    end

    cla_adder32 u_cla (
        .i_a    (r_prod[PROD_W-1:WIDTH+1]),
        .i_b    (w_addend),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Sign-extension bit of the 33-bit sum; its own carry-out is discarded.
    assign w_sum_sign  = r_prod[PROD_W-1] ^ w_addend[WIDTH-1] ^ w_cout;
    assign w_prod_next = {w_sum_sign, w_sum, r_prod[WIDTH:1]};
    assign w_exc_next  = (w_prod_next[PROD_W-1:WIDTH+1] != {WIDTH{w_prod_next[WIDTH]}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_mcand <= data_operandA;
                r_prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result    <= w_prod_next[WIDTH:1];
                    r_exception <= w_exc_next;
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == DONE);
    assign busy           = (r_state == RUN);
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - table-driven and scoreboarded checks for booth_mult_seq
module tb_booth_mult_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    booth_mult_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        edges++;
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      pa;
        longint      pb;
        longint      p;
        logic [63:0] pv;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        pv = p;
        e.res = pv[31:0];
        e.exc = (p != longint'($signed(pv[31:0])));
        return e;
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic push, input exp_t e);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        if (push) sb_q.push_back(e);
        tick();
        edges         = 0;
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(input string name);
        exp_t e;
        int   n;
        n = 0;
        while (!data_resultRDY && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, edges, 32);
        if (!data_resultRDY) begin
            chk({name, "_rdy_timeout"}, {31'b0, data_resultRDY}, 32'd1);
        end else if (sb_q.size() == 0) begin
            chk({name, "_unexpected_rdy"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_result"}, data_result, e.res);
            chk({name, "_exception"}, {31'b0, data_exception}, {31'b0, e.exc});
            chk({name, "_busy_in_done"}, {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        int   seen;

        vecs[0] = '{32'd3,        32'd4,        32'h0000000C, 1'b0};
        vecs[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
        vecs[2] = '{32'd0,        32'h7FFFFFFF, 32'h00000000, 1'b0};
        vecs[3] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};

        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd1;
        tick();
        tick();
        ctrl_MULT = 1'b0;
        chk("reset_busy",   {31'b0, busy}, 32'd0);
        chk("reset_rdy",    {31'b0, data_resultRDY}, 32'd0);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exc",    {31'b0, data_exception}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            start(vecs[i].a, vecs[i].b, 1'b1, '{res: vecs[i].res, exc: vecs[i].exc});
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd1);
            wait_rdy($sformatf("vec%0d", i));
            tick();
            chk($sformatf("vec%0d_rdy_one_cycle", i), {31'b0, data_resultRDY}, 32'd0);
            chk($sformatf("vec%0d_result_held", i), data_result, vecs[i].res);
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i < 3) ? $urandom_range(0, 40000) : $urandom;
            start(ra, rb, 1'b1, model(ra, rb));
            wait_rdy($sformatf("rand%0d", i));
            tick();
        end

        start(32'd5, 32'd5, 1'b1, model(32'd5, 32'd5));
        repeat (10) tick();
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd7;
        data_operandB = 32'd7;
        tick();
        ctrl_MULT = 1'b0;
        chk("ignore_busy", {31'b0, busy}, 32'd1);
        wait_rdy("ignore_start");
        tick();

        start(32'd1234, 32'd5678, 1'b0, e);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy",   {31'b0, busy}, 32'd0);
        chk("abort_rdy",    {31'b0, data_resultRDY}, 32'd0);
        chk("abort_result", data_result, 32'd0);
        chk("abort_exc",    {31'b0, data_exception}, 32'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (data_resultRDY) seen++;
        end
        chk("abort_no_rdy", seen, 0);
        start(32'd2, 32'hFFFFFFFD, 1'b1, '{res: 32'hFFFFFFFA, exc: 1'b0});
        wait_rdy("after_abort");
        tick();

        start(32'd11, 32'd13, 1'b1, '{res: 32'd143, exc: 1'b0});
        wait_rdy("b2b_first");
        start(32'd9, 32'd9, 1'b1, '{res: 32'd81, exc: 1'b0});
        chk("b2b_accept_busy", {31'b0, busy}, 32'd1);
        chk("b2b_held_early", data_result, 32'd143);
        repeat (15) tick();
        chk("b2b_held_mid", data_result, 32'd143);
        wait_rdy("b2b_second");
        tick();
        chk("b2b_idle", {31'b0, data_resultRDY}, 32'd0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ctrl_MULT  input  1  start request, sampled on each rising edge.
REQ-005 SHALL have port data_operandA  input  32  multiplicand, two's complement, sampled with an accepted start.
REQ-006 SHALL have port data_operandB  input  32  multiplier, two's complement, sampled with an accepted start.
REQ-007 SHALL have port data_result  output  32  low 32 bits of the signed product.
REQ-008 SHALL have port data_exception  output  1  signed overflow of the 32-bit result.
REQ-009 SHALL have port data_resultRDY  output  1  one-cycle result-valid strobe.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept a start when ctrl_MULT=1 in IDLE or DONE: latch A into the multiplicand register, load the 65-bit product register with {32'b0, B, 1'b0}, clear the 5-bit iteration counter and enter RUN.
REQ-013 SHALL, in each RUN cycle, examine product[1:0]: 01 adds the multiplicand to product[64:33]; 10 adds ~multiplicand with carry-in 1; 00 and 11 add nothing.
REQ-014 SHALL arithmetic-shift the updated 65-bit product right by one in the same cycle as the add.
REQ-015 SHALL use sign-extended 33-bit add/subtract and ignore the carry-out.
REQ-016 SHALL perform exactly 32 RUN iterations; RUN moves to DONE on the edge that completes iteration 32 (counter = 31).
REQ-017 SHALL, in DONE, drive data_result = product[32:1].
REQ-018 SHALL, in DONE, drive data_exception = 1 iff product[64:33] is not all equal to product[32].
REQ-019 SHALL assert data_resultRDY only in DONE, for exactly one cycle; the edge that samples the start is edge 0, and RDY is high in the cycle after edge 32.
REQ-020 SHALL leave DONE to IDLE on the next edge unless a new start is accepted there (REQ-012).
REQ-021 SHALL hold data_result and data_exception at their last DONE values until the next DONE.
REQ-022 SHALL ignore ctrl_MULT in RUN: no restart and no operand resampling.
REQ-023 SHALL drive busy = 1 exactly in RUN.

Reset
REQ-024 SHALL, on reset=1 at an edge, enter IDLE, clear the product, multiplicand and counter, and drive data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-025 SHALL give reset priority over ctrl_MULT and over any RUN or DONE activity.
REQ-026 SHALL abort an in-flight operation on reset mid-RUN, with no RDY strobe for the aborted operation.

Structure
REQ-027 SHALL take the state enum (IDLE/RUN/DONE), WIDTH=32, ITERS=32 and the product width 65 from the shared package mult_pkg.
REQ-028 SHALL instance exactly one sub-module, cla_adder32: a 32-bit carry-lookahead adder built from 8-bit group generate/propagate blocks, used for both add and subtract.
REQ-029 SHALL handle the 33rd (sign) bit outside cla_adder32 with its own sign/carry logic.
REQ-030 SHALL contain no combinational path from ctrl_MULT or the operands to any output.

Verification
REQ-031 SHALL cover: A=3, B=4, start -> after 32 edges RDY=1 for one cycle, result=0x0000000C, exception=0.
REQ-032 SHALL cover: A=-7, B=6 -> result=0xFFFFFFD6, exception=0; A=0, B=0x7FFFFFFF -> result=0, exception=0.
REQ-033 SHALL cover: A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-034 SHALL cover: start (5*5), then ctrl_MULT=1 with new operands at iteration 10 -> ignored; RDY after 32 edges with result=25.
REQ-035 SHALL cover: start, reset=1 at iteration 10 -> IDLE, busy=0, all outputs 0, no RDY; a following start (2*-3) -> result=0xFFFFFFFA.
REQ-036 SHALL cover: ctrl_MULT=1 in the DONE cycle with 9*9 -> back-to-back accept, RDY again 32 edges later, result=81; the previous result stays valid until then.
